// File: rtl/cache_types_pkg.sv
// Shared types and select encodings for the N-way cache controller.
package cache_types_pkg;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_PMEM = 2'b01,
    WE_CPU  = 2'b10
  } we_mode_e;

  localparam logic ADDR_SEL_WB  = 1'b0;
  localparam logic ADDR_SEL_CPU = 1'b1;
  localparam logic DIN_SEL_PMEM = 1'b0;
  localparam logic DIN_SEL_CPU  = 1'b1;

endpackage

// File: rtl/nway_cache_control_chk.sv
// Protocol checker for the cache controller: hit uniqueness and pmem/CPU handshakes.
module nway_cache_control_chk
  import cache_types_pkg::*;
#(
  parameter int WAYS = 4
) (
  input logic            clk,
  input logic            rst,
  input state_e          state,
  input logic            mem_read,
  input logic            mem_write,
  input logic [WAYS-1:0] hit_vec,
  input logic            mem_resp,
  input logic            pmem_read,
  input logic            pmem_write
);

  always @(posedge clk) begin
    if (!rst) begin
      if (state == CHECK && (mem_read || mem_write)) begin
        assert ($onehot0(hit_vec)) else $error("multi-hot hit_vec %b", hit_vec);
      end
      assert (!(pmem_read && pmem_write)) else $error("pmem_read and pmem_write both high");
      assert (!mem_resp || state == CHECK) else $error("mem_resp outside CHECK");
    end
  end

endmodule

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU: heap-ordered node bits, node 0 is the root,
// a 0 bit points the victim search at the lower half.
module plru_tree #(
  parameter  int WAYS    = 4,
  parameter  int S_INDEX = 3,
  localparam int W_IDX   = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] rd_set,
  output logic [W_IDX-1:0]   victim,
  input  logic               upd_en,
  input  logic [S_INDEX-1:0] upd_set,
  input  logic [W_IDX-1:0]   upd_way
);

  localparam int NUM_SETS = 2**S_INDEX;
  localparam int NODES    = WAYS - 1;

  logic [NODES-1:0] bits_q [NUM_SETS];
  logic [NODES-1:0] bits_d [NUM_SETS];
  logic [NODES-1:0] upd_bits_s;

  // Victim search: follow each node's pointer from the root down to a leaf.
  always_comb begin
    int               node_s;
    logic [NODES-1:0] cur_s;
    cur_s  = bits_q[rd_set];
    node_s = 0;
    victim = '0;
    for (int lvl = 0; lvl < W_IDX; lvl++) begin
      victim[W_IDX-1-lvl] = cur_s[node_s];
      node_s = 2*node_s + 1 + int'(cur_s[node_s]);
    end
  end

  // Touch: every node on the accessed way's path is turned away from it.
  always_comb begin
    int node_s;
    upd_bits_s = bits_q[upd_set];
    node_s     = 0;
    for (int lvl = 0; lvl < W_IDX; lvl++) begin
      upd_bits_s[node_s] = ~upd_way[W_IDX-1-lvl];
      node_s = 2*node_s + 1 + int'(upd_way[W_IDX-1-lvl]);
    end
  end

  always_comb begin
    bits_d = bits_q;
    if (upd_en) bits_d[upd_set] = upd_bits_s;
    else        bits_d[upd_set] = bits_q[upd_set];
  end

  always_ff @(posedge clk) begin
    if (rst) bits_q <= '{default: '0};
    else     bits_q <= bits_d;
  end

endmodule

// File: rtl/nway_cache_control.sv
// Control FSM for an N-way write-back, write-allocate cache with tree PLRU.
// Optional hit/miss/writeback counters when CACHE_PERF_CNT_EN is defined.
module nway_cache_control
  import cache_types_pkg::*;
#(
  parameter  int WAYS    = 4,
  parameter  int S_INDEX = 3,
  localparam int W_IDX   = $clog2(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               mem_resp,
  input  logic [S_INDEX-1:0] set_idx,
  input  logic [WAYS-1:0]    hit_vec,
  input  logic [WAYS-1:0]    valid_vec,
  input  logic [WAYS-1:0]    dirty_vec,
  input  logic               pmem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               pmem_addr_sel,
  output logic               data_in_sel,
  output logic [W_IDX-1:0]   way_sel,
  output logic [WAYS-1:0]    data_we,
  output logic [1:0]         data_we_mode,
  output logic [WAYS-1:0]    ld_tag,
  output logic [WAYS-1:0]    ld_valid,
  output logic [WAYS-1:0]    ld_dirty,
  output logic               valid_in,
  output logic               dirty_in
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count,
  output logic [31:0]        wb_count
`endif
);

  state_e           state_q, state_d;
  logic [W_IDX-1:0] victim_q, victim_d;
  logic [W_IDX-1:0] hit_way_s, inv_way_s, plru_victim_s, miss_way_s;
  logic             req_s, hit_s, plru_upd_s;
  we_mode_e         we_mode_s;

  function automatic logic [WAYS-1:0] way_onehot(input logic [W_IDX-1:0] w);
    way_onehot = WAYS'(1) << w;
  endfunction

  plru_tree #(.WAYS(WAYS), .S_INDEX(S_INDEX)) u_plru (
    .clk     (clk),
    .rst     (rst),
    .rd_set  (set_idx),
    .victim  (plru_victim_s),
    .upd_en  (plru_upd_s),
    .upd_set (set_idx),
    .upd_way (hit_way_s)
  );

  // Lowest-index hit and lowest-index invalid way.
  always_comb begin
    hit_way_s = '0;
    inv_way_s = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      hit_way_s = hit_vec[w]    ? W_IDX'(w) : hit_way_s;
      inv_way_s = !valid_vec[w] ? W_IDX'(w) : inv_way_s;
    end
  end

  assign req_s        = mem_read | mem_write;
  assign hit_s        = |hit_vec;
  assign miss_way_s   = (&valid_vec) ? plru_victim_s : inv_way_s;
  assign data_we_mode = we_mode_s;

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = ADDR_SEL_CPU;
    data_in_sel   = DIN_SEL_CPU;
    way_sel       = '0;
    data_we       = '0;
    we_mode_s     = WE_NONE;
    ld_tag        = '0;
    ld_valid      = '0;
    ld_dirty      = '0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    plru_upd_s    = 1'b0;
    case (state_q)
      CHECK: begin
        if (req_s && hit_s) begin
          way_sel    = hit_way_s;
          mem_resp   = 1'b1;
          plru_upd_s = 1'b1;
          if (mem_write) begin
            data_we   = way_onehot(hit_way_s);
            we_mode_s = WE_CPU;
            ld_dirty  = way_onehot(hit_way_s);
            dirty_in  = 1'b1;
          end else begin
            data_we   = '0;
          end
        end else if (req_s) begin
          // The victim is frozen here so later valid/dirty changes cannot move it.
          victim_d = miss_way_s;
          way_sel  = miss_way_s;
          state_d  = dirty_vec[miss_way_s] ? WRITEBACK : FILL;
        end else begin
          state_d = CHECK;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = ADDR_SEL_WB;
        way_sel       = victim_q;
        if (pmem_resp) begin
          ld_dirty = way_onehot(victim_q);
          state_d  = FILL;
        end else begin
          state_d  = WRITEBACK;
        end
      end
      FILL: begin
        pmem_read   = 1'b1;
        data_in_sel = DIN_SEL_PMEM;
        way_sel     = victim_q;
        if (pmem_resp) begin
          data_we   = way_onehot(victim_q);
          we_mode_s = WE_PMEM;
          ld_tag    = way_onehot(victim_q);
          ld_valid  = way_onehot(victim_q);
          ld_dirty  = way_onehot(victim_q);
          valid_in  = 1'b1;
          state_d   = CHECK;
        end else begin
          state_d   = FILL;
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (mem_resp && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
    else hit_cnt_d = hit_cnt_q;
    if (state_q == CHECK && state_d != CHECK && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
    else miss_cnt_d = miss_cnt_q;
    if (state_q == WRITEBACK && pmem_resp && wb_cnt_q != 32'hFFFF_FFFF) wb_cnt_d = wb_cnt_q + 32'd1;
    else wb_cnt_d = wb_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      wb_cnt_q   <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

  nway_cache_control_chk #(.WAYS(WAYS)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .state      (state_q),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .hit_vec    (hit_vec),
    .mem_resp   (mem_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write)
  );

endmodule

// File: tb/tb_nway_cache_control.sv
// Bench for nway_cache_control: acts as datapath and adapter, predicts strobes
// from a timestamp-based model of the cache contents and replacement order.
module tb_nway_cache_control;

  localparam int WAYS     = 4;
  localparam int S_INDEX  = 3;
  localparam int NUM_SETS = 8;

  logic               clk;
  logic               rst;
  logic               mem_read, mem_write, mem_resp;
  logic [S_INDEX-1:0] set_idx;
  logic [WAYS-1:0]    hit_vec, valid_vec, dirty_vec;
  logic               pmem_resp, pmem_read, pmem_write, pmem_addr_sel, data_in_sel;
  logic [1:0]         way_sel;
  logic [WAYS-1:0]    data_we, ld_tag, ld_valid, ld_dirty;
  logic [1:0]         data_we_mode;
  logic               valid_in, dirty_in;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]        hit_count, miss_count, wb_count;
`endif

  nway_cache_control #(.WAYS(WAYS), .S_INDEX(S_INDEX)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .data_in_sel(data_in_sel), .way_sel(way_sel),
    .data_we(data_we), .data_we_mode(data_we_mode), .ld_tag(ld_tag), .ld_valid(ld_valid),
    .ld_dirty(ld_dirty), .valid_in(valid_in), .dirty_in(dirty_in)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned tag_m   [NUM_SETS][WAYS];
  bit          valid_m [NUM_SETS][WAYS];
  bit          dirty_m [NUM_SETS][WAYS];
  int unsigned stamp_m [NUM_SETS][WAYS];
  int unsigned now_m;
  int          cur_set;
  int unsigned cur_tag;
  int          exp_hits, exp_misses, exp_wbs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int w);
    logic [3:0] one;
    one = 4'd1;
    return one << w;
  endfunction

  task automatic drive_vecs();
    set_idx = S_INDEX'(cur_set);
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = valid_m[cur_set][w];
      dirty_vec[w] = dirty_m[cur_set][w];
      hit_vec[w]   = valid_m[cur_set][w] && (tag_m[cur_set][w] == cur_tag);
    end
  endtask

  function automatic int unsigned newest(input int s, input int lo, input int n);
    int unsigned m;
    m = 0;
    for (int w = lo; w < lo + n; w++) if (stamp_m[s][w] > m) m = stamp_m[s][w];
    return m;
  endfunction

  // Replacement reference: first invalid way, else descend into the half whose
  // most recent use is older (never-used halves tie towards the lower half).
  function automatic int model_victim(input int s);
    int lo, n;
    for (int w = 0; w < WAYS; w++) if (!valid_m[s][w]) return w;
    lo = 0;
    n  = WAYS;
    while (n > 1) begin
      n = n / 2;
      if (newest(s, lo + n, n) < newest(s, lo, n)) lo = lo + n;
    end
    return lo;
  endfunction

  function automatic int model_hit(input int s, input int unsigned t);
    for (int w = 0; w < WAYS; w++) if (valid_m[s][w] && tag_m[s][w] == t) return w;
    return -1;
  endfunction

  task automatic plru_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < WAYS; w++) stamp_m[s][w] = 0;
    exp_hits = 0; exp_misses = 0; exp_wbs = 0;
  endtask

  task automatic access(input bit wr, input int s, input int unsigned t, input int lat_wb, input int lat_fill);
    int hw, v;
    @(negedge clk);
    mem_write = wr;
    mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cur_set = s; cur_tag = t;
    drive_vecs();
    hw = model_hit(s, t);
    if (hw < 0) begin
      v = model_victim(s);
      #1;
      chk("miss_check_resp", mem_resp, 0);
      chk("miss_check_pmem", {pmem_read, pmem_write}, 0);
      if (dirty_m[s][v]) begin
        for (int c = 0; c < lat_wb; c++) begin
          @(negedge clk);
          pmem_resp = (c == lat_wb - 1);
          #1;
          chk("wb_pmem_write", pmem_write, 1);
          chk("wb_pmem_read", pmem_read, 0);
          chk("wb_addr_sel", pmem_addr_sel, 0);
          chk("wb_way_sel", way_sel, v);
          chk("wb_mem_resp", mem_resp, 0);
          chk("wb_ld_dirty", ld_dirty, pmem_resp ? oh(v) : 4'd0);
          if (pmem_resp) chk("wb_dirty_in", dirty_in, 0);
        end
        dirty_m[s][v] = 1'b0;
        exp_wbs++;
      end
      for (int c = 0; c < lat_fill; c++) begin
        @(negedge clk);
        pmem_resp = (c == lat_fill - 1);
        #1;
        chk("fill_pmem_read", pmem_read, 1);
        chk("fill_pmem_write", pmem_write, 0);
        chk("fill_addr_sel", pmem_addr_sel, 1);
        chk("fill_din_sel", data_in_sel, 0);
        chk("fill_way_sel", way_sel, v);
        chk("fill_mem_resp", mem_resp, 0);
        chk("fill_data_we", data_we, pmem_resp ? oh(v) : 4'd0);
        if (pmem_resp) begin
          chk("fill_we_mode", data_we_mode, 2'b01);
          chk("fill_ld_tag", ld_tag, oh(v));
          chk("fill_ld_valid", ld_valid, oh(v));
          chk("fill_ld_dirty", ld_dirty, oh(v));
          chk("fill_valid_in", valid_in, 1);
          chk("fill_dirty_in", dirty_in, 0);
        end
      end
      tag_m[s][v] = t; valid_m[s][v] = 1'b1; dirty_m[s][v] = 1'b0;
      exp_misses++;
      @(negedge clk);
      pmem_resp = 1'b0;
      drive_vecs();
      hw = v;
    end
    #1;
    chk("hit_mem_resp", mem_resp, 1);
    chk("hit_way_sel", way_sel, hw);
    chk("hit_pmem", {pmem_read, pmem_write}, 0);
    chk("hit_data_we", data_we, wr ? oh(hw) : 4'd0);
    chk("hit_ld_dirty", ld_dirty, wr ? oh(hw) : 4'd0);
    if (wr) begin
      chk("hit_we_mode", data_we_mode, 2'b10);
      chk("hit_dirty_in", dirty_in, 1);
      chk("hit_din_sel", data_in_sel, 1);
    end
    now_m++;
    stamp_m[s][hw] = now_m;
    if (wr) dirty_m[s][hw] = 1'b1;
    exp_hits++;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    chk("idle_mem_resp", mem_resp, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    set_idx = '0; hit_vec = '0; valid_vec = '0; dirty_vec = '0;
    now_m = 0; cur_set = 0; cur_tag = 0;
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        tag_m[s][w] = 0; valid_m[s][w] = 1'b0; dirty_m[s][w] = 1'b0;
      end
    plru_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem", {pmem_read, pmem_write}, 0);
    chk("rst_addr_sel", pmem_addr_sel, 1);
    chk("rst_din_sel", data_in_sel, 1);
    chk("rst_way_sel", way_sel, 0);
    chk("rst_strobes", {data_we, ld_tag, ld_valid, ld_dirty}, 0);
    chk("rst_we_mode", data_we_mode, 0);
    chk("rst_in_bits", {valid_in, dirty_in}, 0);

    // First miss: empty set 0, fill answered on the fifth cycle.
    access(1'b0, 0, 32'h1, 1, 5);

    // Fill set 2 with A..D, hit A, then E evicts way 2 without writeback.
    for (int i = 0; i < 4; i++) access(1'b0, 2, 32'hA + i, 2, 2);
    access(1'b0, 2, 32'hA, 1, 1);
    chk("e_victim_is_2", model_victim(2), 2);
    access(1'b0, 2, 32'hE, 1, 3);

    // Write hit to B (way 1), then steer PLRU so F evicts dirty way 1.
    access(1'b1, 2, 32'hB, 1, 1);
    access(1'b0, 2, 32'hA, 1, 1);
    access(1'b0, 2, 32'hD, 1, 1);
    chk("f_victim_is_1", model_victim(2), 1);
    access(1'b0, 2, 32'hF, 3, 2);

    // valid=1011, valid ways dirty: invalid way 2 is filled directly.
    for (int w = 0; w < WAYS; w++) begin
      tag_m[5][w] = 100 + w; valid_m[5][w] = (w != 2); dirty_m[5][w] = (w != 2);
    end
    access(1'b0, 5, 32'd200, 2, 2);

    // Reset in the middle of a fill.
    @(negedge clk);
    mem_read = 1'b1; cur_set = 6; cur_tag = 50; drive_vecs();
    @(negedge clk);
    #1;
    chk("pre_rst_pmem_read", pmem_read, 1);
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_pmem", {pmem_read, pmem_write}, 0);
    chk("post_rst_mem_resp", mem_resp, 0);
    chk("post_rst_addr_sel", pmem_addr_sel, 1);
    plru_reset();
    chk("zeroed_plru_victim", model_victim(2), 0);
    access(1'b0, 2, 32'h77, 2, 2);

    // Random traffic over a small tag pool so hits, clean and dirty misses all occur.
    for (int i = 0; i < 150; i++)
      access(1'($urandom_range(0, 1)), int'($urandom_range(0, NUM_SETS - 1)),
             $urandom_range(0, 5), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));

`ifdef CACHE_PERF_CNT_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
    chk("wb_count", wb_count, exp_wbs);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
